// File: rtl/axi_slave_mem.sv
// AXI4 memory-mapped responder backed by a byte-enabled RAM.
// The write and read paths run independently. Each path allows one outstanding
// INCR burst at a time. All interface outputs are registered.
module axi_slave_mem #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 8,
  parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int unsigned MEM_WORDS      = 4096
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awlock,
  input  logic [3:0]                s_axi_awcache,
  input  logic [2:0]                s_axi_awprot,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arlock,
  input  logic [3:0]                s_axi_arcache,
  input  logic [2:0]                s_axi_arprot,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int unsigned OFFS = $clog2(AXI_STRB_WIDTH);
  localparam int unsigned IDXW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} r_state_t;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  w_state_t                w_state;
  logic [AXI_ID_WIDTH-1:0] aw_id_q;
  logic [IDXW-1:0]         w_idx;
  logic [7:0]              aw_len_q;
  logic [7:0]              w_cnt;
  logic                    w_beat;
  logic                    w_hit_len;

  r_state_t                r_state;
  logic [AXI_ID_WIDTH-1:0] ar_id_q;
  logic [IDXW-1:0]         r_idx;
  logic [7:0]              ar_len_q;
  logic [7:0]              r_cnt;

  // Size, burst type, lock, cache and protection are not used. The burst is
  // always treated as full-width INCR. Address bits outside the word index are
  // also not used.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awsize, s_axi_awburst, s_axi_awlock, s_axi_awcache,
                           s_axi_awprot, s_axi_arsize, s_axi_arburst, s_axi_arlock,
                           s_axi_arcache, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

  assign w_beat    = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready;
  assign w_hit_len = (w_cnt == aw_len_q);

  // Write FSM: accept AW, then absorb beats, then issue the B response.
  // The burst ends on wlast or on the awlen-th beat, whichever comes first.
  // If only one of those two conditions is true on the final beat, the
  // response is SLVERR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state       <= W_IDLE;
      aw_id_q       <= '0;
      w_idx         <= '0;
      aw_len_q      <= '0;
      w_cnt         <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid && s_axi_awready) begin
            aw_id_q       <= s_axi_awid;
            w_idx         <= s_axi_awaddr[OFFS +: IDXW];
            aw_len_q      <= s_axi_awlen;
            w_cnt         <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end else begin
            s_axi_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_idx <= w_idx + 1'b1;
            w_cnt <= w_cnt + 1'b1;
            if (s_axi_wlast || w_hit_len) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= aw_id_q;
              s_axi_bresp  <= (s_axi_wlast != w_hit_len) ? 2'b10 : 2'b00;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // RAM write port. Only bytes whose strobe bit is set are written.
  always_ff @(posedge clk_i) begin
    if (w_beat) begin
      for (int unsigned b = 0; b < AXI_STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM: each beat is one fetch cycle followed by one send cycle.
  // The RAM read uses a non-blocking assignment, so a same-cycle write to the
  // same word returns the old data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= R_IDLE;
      ar_id_q       <= '0;
      r_idx         <= '0;
      ar_len_q      <= '0;
      r_cnt         <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= '0;
      s_axi_rlast   <= 1'b0;
    end else begin
      s_axi_rresp <= 2'b00;
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            ar_id_q       <= s_axi_arid;
            r_idx         <= s_axi_araddr[OFFS +: IDXW];
            ar_len_q      <= s_axi_arlen;
            r_cnt         <= '0;
            s_axi_arready <= 1'b0;
            r_state       <= R_FETCH;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_FETCH: begin
          s_axi_rdata  <= mem[r_idx];
          s_axi_rid    <= ar_id_q;
          s_axi_rlast  <= (r_cnt == ar_len_q);
          s_axi_rvalid <= 1'b1;
          r_state      <= R_SEND;
        end
        R_SEND: begin
          if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            if (s_axi_rlast) begin
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_cnt   <= r_cnt + 1'b1;
              r_state <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- AXI4 memory-mapped responder: the target end of the AXI master interface driven by the DMA-based tester.
- Accepts INCR write and read bursts, stores write data in an internal byte-enabled RAM, and returns read data.
- Used as the on-chip loopback target in tester simulation and bring-up, in place of HBM.
- One outstanding write burst and one outstanding read burst; the write and read paths are independent.

Parameters:
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 64, data width; power of 2, at least 32.
- AXI_ID_WIDTH, 8, transaction ID width.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, byte strobe width.
- MEM_WORDS, 4096, RAM depth in data words; power of 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- s_axi_awid, s_axi_arid  in  AXI_ID_WIDTH  write/read request ID.
- s_axi_awaddr, s_axi_araddr  in  AXI_ADDR_WIDTH  byte start address.
- s_axi_awlen, s_axi_arlen  in  8  beats minus 1.
- s_axi_awsize/awburst/awlock/awcache/awprot and the ar equivalents  in  3/2/1/4/3  accepted and ignored; full-width INCR is implied.
- s_axi_awvalid, s_axi_arvalid  in  1  request valid.
- s_axi_awready, s_axi_arready  out  1  request ready.
- s_axi_wdata  in  AXI_DATA_WIDTH  write data.
- s_axi_wstrb  in  AXI_STRB_WIDTH  byte enables.
- s_axi_wlast, s_axi_wvalid  in  1  last beat / valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bid  out  AXI_ID_WIDTH  response ID.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  response valid.
- s_axi_bready  in  1  response ready.
- s_axi_rid  out  AXI_ID_WIDTH  read ID.
- s_axi_rdata  out  AXI_DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response; always OKAY (2'b00).
- s_axi_rlast, s_axi_rvalid  out  1  last beat / valid.
- s_axi_rready  in  1  read data ready.

Behaviour:
- Reset: every output is registered. While rst_ni is low: all ready/valid outputs are 0; id, resp, data and last outputs are 0; both FSMs are in IDLE.
- RAM contents are not reset.
- Word index = addr[$clog2(AXI_STRB_WIDTH) +: $clog2(MEM_WORDS)]. Low unaligned bits are ignored.
- The index increments by 1 per beat and wraps modulo MEM_WORDS.
- Write FSM W_IDLE → W_DATA → W_RESP:
  - W_IDLE: awready=1. On awvalid&&awready, capture awid, the start index and awlen; clear the beat count and the err flag; go to W_DATA. awready=0 from the next cycle.
  - W_DATA: wready=1. Each wvalid beat writes the RAM bytes whose wstrb bit is 1, then increments index and count.
  - W_DATA termination: the burst ends on the beat where wlast=1 OR count==awlen. err is set if wlast != (count==awlen) on that beat. Go to W_RESP with wready=0 next cycle.
  - W_RESP: bvalid=1, bid=captured ID, bresp = err ? 2'b10 (SLVERR) : 2'b00. bid/bresp are held stable until bready. On bvalid&&bready go to W_IDLE.
  - Minimum write turnaround: AW accept cycle, N data cycles, 1 B cycle.
- Read FSM R_IDLE → R_FETCH → R_SEND:
  - R_IDLE: arready=1. On handshake, capture arid, index and arlen; count=0.
  - R_FETCH: the RAM is read synchronously at index.
  - R_SEND: rvalid=1, rdata = RAM output, rid = captured ID, rlast = (count==arlen). All are held stable while rready=0.
  - On rvalid&&rready: if rlast go to R_IDLE, else increment index/count and return to R_FETCH.
  - Throughput is 1 beat per 2 cycles; there is no back-to-back beat requirement.
- Read/write collision: same-cycle write and read of the same word returns the pre-write data (read-first).
- AW is not accepted while a write is in W_DATA/W_RESP. AR is not accepted while a read is active. Both are back-pressured by ready=0.
- Asynchronous reset mid-burst: both FSMs return to IDLE immediately and the partial burst is dropped. Bytes already written stay in RAM.

Test Plan:
- Write awaddr=0x0, awlen=3, data 0xDEADBEEF_DEADBEEF/0xCAFEF00D_CAFEF00D alternating, wstrb all 1s → bresp=0, bid=awid; read back arlen=3 → same 4 words, rlast only on beat 3, rresp=0.
- Write 0xFFFF…FF to word 5, then wstrb=0x0F with data 0 → read of word 5 returns 0xFFFFFFFF_00000000.
- Write awlen=3 with wlast asserted on beat 1 → burst ends after 2 beats, bresp=2'b10; same awlen=3 with wlast low on beat 3 → bresp=2'b10 and wready drops after 4 beats.
- Burst starting at word MEM_WORDS-2 with awlen=3 → words MEM_WORDS-2, MEM_WORDS-1, 0, 1 written; a wrapping read returns them in order.
- Hold rready=0 for 5 cycles mid-read and bready=0 for 3 cycles → rdata/rid/rlast and bid/bresp stay constant; no beat is lost or duplicated.
- Assert rst_ni=0 during W_DATA beat 2 → all valids/readys are 0 asynchronously; after release awready=1 on the first clock edge and a fresh burst completes with bresp=0.
